// File: rtl/lane_pkg.sv
// Shared constants for the lane controller.
// Holds the tile codes, the row map of the 20x15 grid, and the pattern, direction
// and period of each of the 12 moving lanes.
// Lane index mapping: water rows 1..5 -> lanes 0..4, road rows 7..13 -> lanes 5..11.
// Helper functions:
//   lane_idx   - row to lane index
//   cell_code  - per-lane occupancy to tile code
//   eff_period - score-adjusted lane period
package lane_pkg;

  localparam logic [3:0] TILE_GRASS = 4'd0;
  localparam logic [3:0] TILE_ROAD  = 4'd1;
  localparam logic [3:0] TILE_WATER = 4'd2;
  localparam logic [3:0] TILE_LOG   = 4'd3;
  localparam logic [3:0] TILE_GOAL  = 4'd4;
  localparam logic [3:0] TILE_CAR   = 4'd5;

  localparam logic [5:0] ROW_GOAL        = 6'd0;
  localparam logic [5:0] ROW_WATER_FIRST = 6'd1;
  localparam logic [5:0] ROW_WATER_LAST  = 6'd5;
  localparam logic [5:0] ROW_MEDIAN      = 6'd6;
  localparam logic [5:0] ROW_ROAD_FIRST  = 6'd7;
  localparam logic [5:0] ROW_ROAD_LAST   = 6'd13;
  localparam logic [5:0] ROW_START       = 6'd14;

  localparam int unsigned NUM_LANES = 12;
  localparam int unsigned LANE_W    = 20;

  // Bit i of a pattern is the occupancy of column i at offset 0.
  localparam logic [19:0] LANE_PATTERN [NUM_LANES] = '{
    20'h0F0F0, 20'h000FF, 20'hE38E3, 20'h3C3C3, 20'h1F01F,
    20'h11111, 20'h0C30C, 20'h00003, 20'h60606, 20'h08421, 20'h30030, 20'h81818
  };

  // 0 = scroll left (offset increments), 1 = scroll right (offset decrements).
  localparam logic LANE_DIR [NUM_LANES] = '{
    1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0
  };

  // Base ticks per one-column shift, 1..4.
  localparam logic [2:0] LANE_PERIOD [NUM_LANES] = '{
    3'd2, 3'd3, 3'd1, 3'd2, 3'd4,
    3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd2
  };

  function automatic logic [2:0] eff_period(input logic [2:0] base, input logic [2:0] dec);
    return (base > dec) ? 3'(base - dec) : 3'd1;
  endfunction

  // Only meaningful for water and road rows.
  function automatic logic [3:0] lane_idx(input logic [5:0] row);
    return 4'((row <= ROW_WATER_LAST) ? row - ROW_WATER_FIRST : row - 6'd2);
  endfunction

  // occ holds each lane's occupancy for the column of interest; valid is the
  // in-grid check for that row/column pair.
  function automatic logic [3:0] cell_code(input logic valid, input logic [5:0] row,
                                           input logic [NUM_LANES-1:0] occ);
    logic [3:0] code;
    code = TILE_GRASS;
    if (valid) begin
      if (row == ROW_GOAL) begin
        code = TILE_GOAL;
      end else if (row >= ROW_WATER_FIRST && row <= ROW_WATER_LAST) begin
        code = occ[lane_idx(row)] ? TILE_LOG : TILE_WATER;
      end else if (row >= ROW_ROAD_FIRST && row <= ROW_ROAD_LAST) begin
        code = occ[lane_idx(row)] ? TILE_CAR : TILE_ROAD;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/lane_scroller.sv
// One scrolling lane: a period counter and a column offset register.
// Provides combinational occupancy lookups for two columns (scan and frog).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   tick_i                   base scroll tick (1 cycle)
//   period_i                 effective period in base ticks (>= 1)
//   scan_col_i, frog_col_i   columns to look up
//   scan_occ_o, frog_occ_o   pattern[(col + offset) mod Width]
//   shift_o                  high in the cycle whose edge shifts the offset
module lane_scroller
  import lane_pkg::*;
#(
  parameter int unsigned      Width   = LANE_W,
  parameter logic [Width-1:0] Pattern = '0,
  parameter logic             Dir     = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic [2:0] period_i,
  input  logic [4:0] scan_col_i,
  input  logic [4:0] frog_col_i,
  output logic       scan_occ_o,
  output logic       frog_occ_o,
  output logic       shift_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [4:0] off_q, off_d;

  function automatic logic lookup(input logic [4:0] col, input logic [4:0] off);
    logic [5:0] sum;
    sum = {1'b0, col} + {1'b0, off};
    if (sum >= 6'(Width)) begin
      sum = sum - 6'(Width);
    end
    // Out-of-grid columns are masked by the caller; keep the index in range anyway.
    return (sum < 6'(Width)) ? Pattern[sum[4:0]] : 1'b0;
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    off_d   = off_q;
    shift_o = 1'b0;
    if (tick_i) begin
      // >= so a period that drops under the running count still shifts promptly.
      if ({1'b0, cnt_q} + 4'd1 >= {1'b0, period_i}) begin
        cnt_d   = '0;
        shift_o = 1'b1;
        if (Dir) begin
          off_d = (off_q == 5'd0) ? 5'(Width - 1) : off_q - 5'd1;
        end else begin
          off_d = (off_q == 5'(Width - 1)) ? 5'd0 : off_q + 5'd1;
        end
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  end

  assign scan_occ_o = lookup(scan_col_i, off_q);
  assign frog_occ_o = lookup(frog_col_i, off_q);

endmodule

// File: rtl/lane_ctrl.sv
// Lane controller: owns the scrolling car/log lanes and answers tile-code queries.
// Optional feature macro: LANE_SPEEDUP_EN shortens each lane period by i_Score[6:4]
// (floor 1); without it i_Score is ignored.
// Ports:
//   i_Clk, i_Rst_n                     clock, async active-low reset
//   i_Frogger_X/Y                      frog position
//   i_Col/Row_Count_Div                scanned tile
//   i_Score                            score (speed-up only)
//   i_Pause                            freezes scrolling
//   o_Bitmap_Data                      tile code of scanned tile, 1-cycle latency
//   o_Collided                         1-cycle hazard pulse
//   o_On_Log                           frog on a log tile
//   o_Log_Shift/o_Log_Dir              frog's log lane scrolled, and which way
module lane_ctrl
  import lane_pkg::*;
#(
  parameter int unsigned c_TICK_DIV    = 2500000,
  parameter int unsigned c_GAME_WIDTH  = 20,
  parameter int unsigned c_GAME_HEIGHT = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  input  logic [6:0] i_Score,
  input  logic       i_Pause,
  output logic [3:0] o_Bitmap_Data,
  output logic       o_Collided,
  output logic       o_On_Log,
  output logic       o_Log_Shift,
  output logic       o_Log_Dir
);

  localparam int unsigned TickW = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;

  logic [TickW-1:0] presc_q, presc_d;
  logic             base_tick;

  always_comb begin
    presc_d   = presc_q;
    base_tick = 1'b0;
    if (!i_Pause) begin
      if (presc_q == TickW'(c_TICK_DIV - 1)) begin
        presc_d   = '0;
        base_tick = 1'b1;
      end else begin
        presc_d = presc_q + TickW'(1);
      end
    end
  end

  logic [2:0] score_dec;
`ifdef LANE_SPEEDUP_EN
  assign score_dec = i_Score[6:4];
`else
  logic unused_score;
  assign unused_score = ^i_Score;
  assign score_dec    = 3'd0;
`endif

  logic [NUM_LANES-1:0] scan_occ, frog_occ, lane_shift;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_scroller #(
      .Width  (c_GAME_WIDTH),
      .Pattern(LANE_PATTERN[l]),
      .Dir    (LANE_DIR[l])
    ) u_lane (
      .clk_i     (i_Clk),
      .rst_ni    (i_Rst_n),
      .tick_i    (base_tick),
      .period_i  (eff_period(LANE_PERIOD[l], score_dec)),
      .scan_col_i(i_Col_Count_Div[4:0]),
      .frog_col_i(i_Frogger_X[4:0]),
      .scan_occ_o(scan_occ[l]),
      .frog_occ_o(frog_occ[l]),
      .shift_o   (lane_shift[l])
    );
  end

  logic       scan_valid, frog_valid;
  logic       frog_in_water, frog_lane_shift;
  logic [3:0] frog_lane, frog_code;

  assign scan_valid = (i_Col_Count_Div < 6'(c_GAME_WIDTH)) &&
                      (i_Row_Count_Div < 6'(c_GAME_HEIGHT));
  assign frog_valid = (i_Frogger_X < 6'(c_GAME_WIDTH)) && (i_Frogger_Y < 6'(c_GAME_HEIGHT));
  assign frog_in_water = (i_Frogger_Y >= ROW_WATER_FIRST) && (i_Frogger_Y <= ROW_WATER_LAST);
  assign frog_lane     = lane_idx(i_Frogger_Y);
  assign frog_lane_shift = frog_in_water && lane_shift[frog_lane];

  logic [3:0] bitmap_q, bitmap_d;
  logic       hazard_q, hazard_d;
  logic       collided_q, collided_d;
  logic       on_log_q, on_log_d;
  logic       log_shift_q, log_shift_d;
  logic       log_dir_q, log_dir_d;

  always_comb begin
    bitmap_d    = cell_code(scan_valid, i_Row_Count_Div, scan_occ);
    frog_code   = cell_code(frog_valid, i_Frogger_Y, frog_occ);
    hazard_d    = (frog_code == TILE_CAR) || (frog_code == TILE_WATER);
    collided_d  = hazard_d && !hazard_q;
    on_log_d    = (frog_code == TILE_LOG);
    // on_log_q is pre-shift: the frog was riding this log when its lane moved.
    log_shift_d = frog_lane_shift && on_log_q;
    log_dir_d   = log_shift_d ? LANE_DIR[frog_lane] : log_dir_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q     <= '0;
      bitmap_q    <= '0;
      hazard_q    <= 1'b0;
      collided_q  <= 1'b0;
      on_log_q    <= 1'b0;
      log_shift_q <= 1'b0;
      log_dir_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      bitmap_q    <= bitmap_d;
      hazard_q    <= hazard_d;
      collided_q  <= collided_d;
      on_log_q    <= on_log_d;
      log_shift_q <= log_shift_d;
      log_dir_q   <= log_dir_d;
    end
  end

  assign o_Bitmap_Data = bitmap_q;
  assign o_Collided    = collided_q;
  assign o_On_Log      = on_log_q;
  assign o_Log_Shift   = log_shift_q;
  assign o_Log_Dir     = log_dir_q;

endmodule

// File: tb/tb_lane_ctrl.sv
module tb_lane_ctrl;
  import lane_pkg::*;

  localparam int TICK = 4;

  logic       clk, rst_n, pause;
  logic [5:0] frog_x, frog_y, scan_col, scan_row;
  logic [6:0] score;
  logic [3:0] bm;
  logic       coll, onlog, lshift, ldir;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b1;

  lane_ctrl #(.c_TICK_DIV(TICK), .c_GAME_WIDTH(20), .c_GAME_HEIGHT(15)) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Frogger_X    (frog_x),
    .i_Frogger_Y    (frog_y),
    .i_Col_Count_Div(scan_col),
    .i_Row_Count_Div(scan_row),
    .i_Score        (score),
    .i_Pause        (pause),
    .o_Bitmap_Data  (bm),
    .o_Collided     (coll),
    .o_On_Log       (onlog),
    .o_Log_Shift    (lshift),
    .o_Log_Dir      (ldir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane position follows directly from the number of
  // unpaused cycles since reset.
  function automatic int shifts(input int l, input int n);
    return (n / TICK) / int'(LANE_PERIOD[l]);
  endfunction

  function automatic int offset_of(input int l, input int n);
    int s;
    s = shifts(l, n) % 20;
    return LANE_DIR[l] ? (20 - s) % 20 : s;
  endfunction

  function automatic int model_code(input int row, input int col, input int n);
    int  l;
    logic [19:0] pat;
    logic occ;
    if (col >= 20 || row >= 15) return 0;
    if (row == 0) return 4;
    if (row == 6 || row == 14) return 0;
    l   = (row < 6) ? row - 1 : row - 2;
    pat = LANE_PATTERN[l];
    occ = pat[(col + offset_of(l, n)) % 20];
    if (row < 6) return occ ? 3 : 2;
    return occ ? 5 : 1;
  endfunction

  function automatic bit is_hazard(input int code);
    return code == 5 || code == 2;
  endfunction

  function automatic bit frog_lane_moves(input int row, input int n);
    if (row < 1 || row > 5) return 1'b0;
    return shifts(row - 1, n + 1) != shifts(row - 1, n);
  endfunction

  int   active;
  int   exp_bm;
  logic exp_coll, m_hz, exp_onlog, exp_ls, exp_dir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 0;
      exp_bm    <= 0;
      exp_coll  <= 1'b0;
      m_hz      <= 1'b0;
      exp_onlog <= 1'b0;
      exp_ls    <= 1'b0;
      exp_dir   <= 1'b0;
    end else begin
      exp_bm    <= model_code(int'(scan_row), int'(scan_col), active);
      m_hz      <= is_hazard(model_code(int'(frog_y), int'(frog_x), active));
      exp_coll  <= is_hazard(model_code(int'(frog_y), int'(frog_x), active)) && !m_hz;
      exp_onlog <= model_code(int'(frog_y), int'(frog_x), active) == 3;
      if (!pause && frog_lane_moves(int'(frog_y), active)) begin
        exp_ls <= exp_onlog;
        if (exp_onlog) exp_dir <= LANE_DIR[int'(frog_y) - 1];
      end else begin
        exp_ls <= 1'b0;
      end
      if (!pause) active <= active + 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_bitmap", int'(bm), exp_bm);
      check("model_collided", int'(coll), int'(exp_coll));
      check("model_on_log", int'(onlog), int'(exp_onlog));
      check("model_log_shift", int'(lshift), int'(exp_ls));
      check("model_log_dir", int'(ldir), int'(exp_dir));
    end
  end

  typedef struct {
    logic [5:0] row;
    logic [5:0] col;
    int         exp;
  } vec_t;

  vec_t vecs[13];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_ls, n_coll, cnt;
    rst_n = 1'b0; pause = 1'b0; score = '0;
    frog_x = 6'd0; frog_y = 6'd14; scan_col = 6'd0; scan_row = 6'd0;
    repeat (2) @(negedge clk);
    check("reset_bitmap", int'(bm), 0);
    check("reset_on_log", int'(onlog), 0);
    rst_n = 1'b1;

    // Scroll: row 7 is period 1, direction 0.
    scan_row = 6'd7; scan_col = 6'd3;
    do_reset();
    repeat (4) @(negedge clk);
    check("scroll_off0", int'(bm), 1);
    @(negedge clk);
    check("scroll_off1", int'(bm), 5);
    scan_col = 6'd0;
    repeat (75) @(negedge clk);
    check("scroll_off19", int'(bm), 1);
    @(negedge clk);
    check("scroll_wrap", int'(bm), 5);

    // Car on row 9, columns 0..1 at offset 0.
    pause = 1'b1; frog_x = 6'd0; frog_y = 6'd9;
    do_reset();
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(coll); end
    check("car_pulse1", cnt, 1);
    frog_y = 6'd14;
    repeat (2) @(negedge clk);
    frog_y = 6'd9;
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(coll); end
    check("car_pulse2", cnt, 1);

    // Log on row 2 col 0; lane shifts right at base tick 3 and leaves water.
    pause = 1'b0; frog_x = 6'd0; frog_y = 6'd2;
    do_reset();
    @(negedge clk);
    check("on_log", int'(onlog), 1);
    n_ls = 0; n_coll = 0;
    repeat (20) begin
      @(negedge clk);
      if (lshift) begin
        n_ls++;
        check("log_dir", int'(ldir), 1);
      end
      n_coll += int'(coll);
    end
    check("log_shift_count", n_ls, 1);
    check("log_carry_coll", n_coll, 1);
    check("log_left", int'(onlog), 0);

    // Pause holds offsets and the prescaler.
    frog_y = 6'd14; scan_row = 6'd7; scan_col = 6'd3;
    do_reset();
    repeat (6) @(negedge clk);
    check("pre_pause", int'(bm), 5);
    pause = 1'b1;
    repeat (100) @(negedge clk);
    check("pause_hold", int'(bm), 5);
    pause = 1'b0; scan_col = 6'd2;
    repeat (3) @(negedge clk);
    check("pause_resume", int'(bm), 5);

    // Asynchronous reset mid-count.
    scan_row = 6'd0; scan_col = 6'd4; frog_x = 6'd0; frog_y = 6'd2;
    do_reset();
    repeat (14) @(negedge clk);
    check("pre_rst_bitmap", int'(bm), 4);
    check("pre_rst_dir", int'(ldir), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_bitmap", int'(bm), 0);
    check("async_collided", int'(coll), 0);
    check("async_on_log", int'(onlog), 0);
    check("async_log_shift", int'(lshift), 0);
    check("async_log_dir", int'(ldir), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of lookups at offset 0 (paused so lanes stay aligned).
    pause = 1'b1; frog_y = 6'd14;
    vecs[0]  = '{6'd3,  6'd25, 0};
    vecs[1]  = '{6'd0,  6'd5,  4};
    vecs[2]  = '{6'd14, 6'd3,  0};
    vecs[3]  = '{6'd6,  6'd0,  0};
    vecs[4]  = '{6'd7,  6'd0,  5};
    vecs[5]  = '{6'd7,  6'd1,  1};
    vecs[6]  = '{6'd2,  6'd0,  3};
    vecs[7]  = '{6'd2,  6'd10, 2};
    vecs[8]  = '{6'd9,  6'd1,  5};
    vecs[9]  = '{6'd13, 6'd3,  5};
    vecs[10] = '{6'd20, 6'd0,  0};
    vecs[11] = '{6'd13, 6'd19, 5};
    vecs[12] = '{6'd1,  6'd4,  3};
    for (int i = 0; i < 13; i++) begin
      scan_row = vecs[i].row;
      scan_col = vecs[i].col;
      @(negedge clk);
      check($sformatf("vec%0d", i), int'(bm), vecs[i].exp);
    end

    // Randomized run against the model.
    pause = 1'b0;
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        frog_x = 6'($urandom_range(0, 21));
        frog_y = 6'($urandom_range(0, 16));
      end
      scan_col = 6'($urandom_range(0, 23));
      scan_row = 6'($urandom_range(0, 16));
    end
    @(negedge clk);

`ifdef LANE_SPEEDUP_EN
    // Score 48 drops the period-4 lane on row 5 to one base tick.
    model_on = 1'b0;
    score = 7'd48; pause = 1'b0; frog_y = 6'd14; scan_row = 6'd5; scan_col = 6'd1;
    do_reset();
    repeat (17) @(negedge clk);
    check("speedup", int'(bm), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
